// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int         BCD_W       = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        SHIFT = S_SHIFT,
        DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Request/result bundle between the hash source, the converter and the display stage.
interface bcd_seq_converter_if
    import bcd_pkg::*;
#(
    parameter int WIDTH = 16
);
    // Handshake: the requester raises start with bin_in valid; the converter accepts it
    // only on a rising edge where it is idle (fsm_state == S_IDLE). While busy, start is
    // ignored and not queued. done pulses for one cycle as D5..D1 take the new result;
    // the digits otherwise hold their last value.
    logic                   start;
    logic [WIDTH-1:0]       bin_in;
    logic                   busy;
    logic                   done;
    logic [BCD_W-1:0]       D5_out;
    logic [BCD_W-1:0]       D4_out;
    logic [BCD_W-1:0]       D3_out;
    logic [BCD_W-1:0]       D2_out;
    logic [BCD_W-1:0]       D1_out;
    logic [1:0]             fsm_state;

    modport master (
        output start, bin_in,
        input  busy, done, D5_out, D4_out, D3_out, D2_out, D1_out, fsm_state
    );

    modport slave (
        input  start, bin_in,
        output busy, done, D5_out, D4_out, D3_out, D2_out, D1_out, fsm_state
    );

endinterface

// File: rtl/bcd_add3.sv
// Combinational double-dabble correction cell: a digit of 5 or more gets 3 added.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] corrected
);

    // Inputs stay in 0..9 during conversion, so the 4-bit sum never wraps.
    assign corrected = (digit >= ADD3_THRESH) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential shift-add-3 converter: one correction and shift per clock, WIDTH shifts per
// conversion, result copied to the held digit outputs in a single update.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
)(
    input logic                 sysclk,
    input logic                 reset,
    bcd_seq_converter_if.slave  bus
);

    localparam int         BCD_BITS = DIGITS * BCD_W;
    localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

    state_t               state;
    logic [BCD_BITS-1:0]  bcd_sr;
    logic [BCD_BITS-1:0]  bcd_corr;
    logic [WIDTH-1:0]     bin_sr;
    logic [4:0]           cnt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit     (bcd_sr[g*BCD_W +: BCD_W]),
            .corrected (bcd_corr[g*BCD_W +: BCD_W])
        );
    end

    assign bus.fsm_state = state;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state      <= IDLE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.D5_out <= '0;
            bus.D4_out <= '0;
            bus.D3_out <= '0;
            bus.D2_out <= '0;
            bus.D1_out <= '0;
            bcd_sr     <= '0;
            bin_sr     <= '0;
            cnt        <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_sr   <= bus.bin_in;
                        bcd_sr   <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Corrected digits shift left as one unit with the binary MSB fed in.
                    bcd_sr <= {bcd_corr[BCD_BITS-2:0], bin_sr[WIDTH-1]};
                    bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
                    cnt    <= cnt + 5'd1;
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.D5_out <= bcd_sr[4*BCD_W +: BCD_W];
                    bus.D4_out <= bcd_sr[3*BCD_W +: BCD_W];
                    bus.D3_out <= bcd_sr[2*BCD_W +: BCD_W];
                    bus.D2_out <= bcd_sr[1*BCD_W +: BCD_W];
                    bus.D1_out <= bcd_sr[0*BCD_W +: BCD_W];
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
